// File: rtl/rsa_exp_sequencer_if.sv
// Signal bundle between the RSA exponentiation sequencer, its operand loader
// and the ModuloProduct / Montgomery arithmetic units.
interface rsa_exp_sequencer_if;
  logic         start;
  logic [255:0] y;
  logic [255:0] d;
  logic [255:0] n;
  logic [255:0] result;
  logic         done;
  logic         busy;

  logic         mp_start;
  logic [256:0] mp_n;
  logic [256:0] mp_a;
  logic [256:0] mp_b;
  logic [10:0]  mp_k;
  logic         mp_done;
  logic [256:0] mp_result;

  logic         mont_start;
  logic [255:0] mont_a;
  logic [255:0] mont_b;
  logic [255:0] mont_n;
  logic         mont_done;
  logic [255:0] mont_result;

  modport master (
    input  start, y, d, n, mp_done, mp_result, mont_done, mont_result,
    output result, done, busy, mp_start, mp_n, mp_a, mp_b, mp_k,
           mont_start, mont_a, mont_b, mont_n
  );

  modport slave (
    output start, y, d, n, mp_done, mp_result, mont_done, mont_result,
    input  result, done, busy, mp_start, mp_n, mp_a, mp_b, mp_k,
           mont_start, mont_a, mont_b, mont_n
  );
endinterface

// File: rtl/rsa_exp_sequencer.sv
// Left-to-right-free (LSB-first) square-and-multiply sequencer for y^d mod N.
// Optional macro RSA_EARLY_EXIT_EN stops scanning once no set exponent bits remain.
module rsa_exp_sequencer #(
  parameter int EXP_BITS = 256
) (
  input  logic               clk,
  input  logic               rst,
  rsa_exp_sequencer_if.master bus
);

  localparam logic [256:0] MP_R = 257'd1 << 256;

  typedef enum logic [2:0] {
    IDLE, PREP, PREP_W, MUL, MUL_W, SQR, SQR_W, DONE
  } state_t;

  state_t       state, state_nx;
  logic [255:0] y_r, d_r, n_r, t_r, m_r;
  logic [8:0]   i_r;
  logic [255:0] result_r, mont_a_r, mont_b_r;
  logic [255:0] op_a, op_b;
  logic [256:0] mp_a_r;
  logic         done_r, busy_r, mp_start_r, mont_start_r;

  logic capture, mp_go, mont_go;
  logic load_t_mp, load_t_mont, load_m, inc_i, load_result;
  logic bit_set, stop_scan;
  logic unused_mp_msb;

  assign bit_set = d_r[i_r[7:0]];

`ifdef RSA_EARLY_EXIT_EN
  assign stop_scan = (i_r == 9'(EXP_BITS - 1)) || ((d_r >> (i_r + 9'd1)) == '0);
`else
  assign stop_scan = (i_r == 9'(EXP_BITS - 1));
`endif

  // A unit done coinciding with our own start strobe is stale and must not count.
  always_comb begin
    state_nx    = state;
    capture     = 1'b0;
    mp_go       = 1'b0;
    mont_go     = 1'b0;
    load_t_mp   = 1'b0;
    load_t_mont = 1'b0;
    load_m      = 1'b0;
    inc_i       = 1'b0;
    load_result = 1'b0;
    op_a        = mont_a_r;
    op_b        = mont_b_r;
    case (state)
      IDLE: begin
        if (bus.start) begin
          capture  = 1'b1;
          state_nx = PREP;
        end
      end
      PREP: begin
        mp_go    = 1'b1;
        state_nx = PREP_W;
      end
      PREP_W: begin
        if (bus.mp_done && !mp_start_r) begin
          load_t_mp = 1'b1;
          state_nx  = MUL;
        end
      end
      MUL: begin
        if (bit_set) begin
          op_a     = m_r;
          op_b     = t_r;
          mont_go  = 1'b1;
          state_nx = MUL_W;
        end else begin
          state_nx = SQR;
        end
      end
      MUL_W: begin
        if (bus.mont_done && !mont_start_r) begin
          load_m   = 1'b1;
          state_nx = SQR;
        end
      end
      SQR: begin
        if (stop_scan) begin
          load_result = 1'b1;
          state_nx    = DONE;
        end else begin
          op_a     = t_r;
          op_b     = t_r;
          mont_go  = 1'b1;
          state_nx = SQR_W;
        end
      end
      SQR_W: begin
        if (bus.mont_done && !mont_start_r) begin
          load_t_mont = 1'b1;
          inc_i       = 1'b1;
          state_nx    = MUL;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_r          <= '0;
      d_r          <= '0;
      n_r          <= '0;
      t_r          <= '0;
      m_r          <= '0;
      i_r          <= '0;
      result_r     <= '0;
      mont_a_r     <= '0;
      mont_b_r     <= '0;
      mp_a_r       <= '0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      mp_start_r   <= 1'b0;
      mont_start_r <= 1'b0;
    end else begin
      mp_start_r   <= mp_go;
      mont_start_r <= mont_go;
      busy_r       <= (state_nx != IDLE);
      done_r       <= (state_nx == DONE);
      if (capture) begin
        y_r    <= bus.y;
        d_r    <= bus.d;
        n_r    <= bus.n;
        i_r    <= '0;
        m_r    <= 256'd1;
        mp_a_r <= MP_R;
      end
      if (load_t_mp) begin
        t_r <= bus.mp_result[255:0];
      end
      if (load_t_mont) begin
        t_r <= bus.mont_result;
      end
      if (load_m) begin
        m_r <= bus.mont_result;
      end
      if (inc_i) begin
        i_r <= i_r + 9'd1;
      end
      if (mont_go) begin
        mont_a_r <= op_a;
        mont_b_r <= op_b;
      end
      if (load_result) begin
        result_r <= m_r;
      end
    end
  end

  assign bus.result     = result_r;
  assign bus.done       = done_r;
  assign bus.busy       = busy_r;
  assign bus.mp_start   = mp_start_r;
  assign bus.mp_n       = {1'b0, n_r};
  assign bus.mp_a       = mp_a_r;
  assign bus.mp_b       = {1'b0, y_r};
  assign bus.mp_k       = 11'd256;
  assign bus.mont_start = mont_start_r;
  assign bus.mont_a     = mont_a_r;
  assign bus.mont_b     = mont_b_r;
  assign bus.mont_n     = n_r;
  assign unused_mp_msb  = bus.mp_result[256];

  a_mp_pulse:   assert property (@(posedge clk) disable iff (rst) mp_start_r |=> !mp_start_r);
  a_mont_pulse: assert property (@(posedge clk) disable iff (rst) mont_start_r |=> !mont_start_r);
  a_done_pulse: assert property (@(posedge clk) disable iff (rst) done_r |=> !done_r);

endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// Self-checking bench for rsa_exp_sequencer with behavioral ModuloProduct and
// Montgomery unit models and a scoreboard of expected exponentiation results.
module tb_rsa_exp_sequencer;

`ifdef RSA_EARLY_EXIT_EN
  localparam int PULSES_BASIC = 3;
  localparam int PULSES_ZERO  = 0;
`else
  localparam int PULSES_BASIC = 257;
  localparam int PULSES_ZERO  = 255;
`endif
  localparam logic [255:0] JUNK = {8{32'hdeadbeef}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rsa_exp_sequencer_if ifc ();

  rsa_exp_sequencer #(.EXP_BITS(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  logic         start_s = 1'b0;
  logic [255:0] y_s = '0, d_s = '0, n_s = '0;
  logic         mp_inj = 1'b0, mont_inj = 1'b0;

  logic         mpdone_m = 1'b0;
  logic [256:0] mpres_m = '0;
  logic         mdone_m = 1'b0;
  logic [255:0] mres_m = '0;

  assign ifc.start       = start_s;
  assign ifc.y           = y_s;
  assign ifc.d           = d_s;
  assign ifc.n           = n_s;
  assign ifc.mp_done     = mpdone_m | mp_inj;
  assign ifc.mp_result   = mp_inj ? {1'b1, JUNK} : mpres_m;
  assign ifc.mont_done   = mdone_m | mont_inj;
  assign ifc.mont_result = mont_inj ? JUNK : mres_m;

  int vectors = 0;
  int miscompares = 0;
  logic [255:0] expq[$];

  function automatic logic [255:0] mont_mul(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] n);
    logic [257:0] u;
    u = '0;
    for (int i = 0; i < 256; i++) begin
      if (a[i]) u = u + {2'b00, b};
      if (u[0]) u = u + {2'b00, n};
      u = u >> 1;
    end
    if (u >= {2'b00, n}) u = u - {2'b00, n};
    return u[255:0];
  endfunction

  function automatic logic [256:0] mp_mod(input logic [256:0] a, input logic [256:0] b,
                                          input logic [256:0] n);
    logic [513:0] p;
    p = {257'd0, a} * {257'd0, b};
    p = p % {257'd0, n};
    return p[256:0];
  endfunction

  function automatic logic [255:0] ref_exp(input logic [255:0] y, input logic [255:0] d,
                                           input logic [255:0] n);
    logic [511:0] r, b, nn;
    nn = {256'd0, n};
    r  = 512'd1;
    b  = {256'd0, y} % nn;
    for (int i = 0; i < 256; i++) begin
      if (d[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[255:0];
  endfunction

  function automatic logic [255:0] mix(input logic [255:0] s, input logic [255:0] a,
                                       input logic [255:0] b);
    return {s[254:0], s[255]} ^ a ^ {b[127:0], b[255:128]};
  endfunction

  // Expected operand-stream signature of the square-and-multiply schedule.
  function automatic logic [255:0] model_sig(input logic [255:0] y, input logic [255:0] d,
                                             input logic [255:0] n);
    logic [511:0] tw;
    logic [255:0] t, m, s;
    bit stop;
    tw = {y, 256'd0} % {256'd0, n};
    t  = tw[255:0];
    m  = 256'd1;
    s  = '0;
    for (int i = 0; i < 256; i++) begin
      if (d[i]) begin
        s = mix(s, m, t);
        m = mont_mul(m, t, n);
      end
      stop = (i == 255);
`ifdef RSA_EARLY_EXIT_EN
      if ((d >> (i + 1)) == '0) stop = 1'b1;
`endif
      if (stop) break;
      s = mix(s, t, t);
      t = mont_mul(t, t, n);
    end
    return s;
  endfunction

  // ModuloProduct model
  logic         mp_busy = 1'b0;
  int           mp_cnt = 0;
  logic [256:0] mpa = '0, mpb = '0, mpn = '0;
  int           mp_total = 0, mp_proto = 0;

  always @(posedge clk) begin
    mpdone_m <= 1'b0;
    if (mp_busy) begin
      if (mp_cnt == 1) begin
        mpdone_m <= 1'b1;
        mpres_m  <= mp_mod(mpa, mpb, mpn);
        mp_busy  <= 1'b0;
      end else begin
        mp_cnt <= mp_cnt - 1;
      end
    end
    if (ifc.mp_start) begin
      if (mp_busy) mp_proto <= mp_proto + 1;
      mpa      <= ifc.mp_a;
      mpb      <= ifc.mp_b;
      mpn      <= ifc.mp_n;
      mp_busy  <= 1'b1;
      mp_cnt   <= int'($urandom_range(5, 2));
      mp_total <= mp_total + 1;
    end
  end

  // Montgomery model plus per-run operand statistics
  logic         mont_busy_m = 1'b0, mont_op_valid = 1'b0;
  int           mont_cnt = 0;
  logic [255:0] cap_a = '0, cap_b = '0, cap_n = '0;
  int           mont_pulses = 0, mont_total = 0, eq_cnt = 0, mont_proto = 0, stab_errs = 0;
  logic [255:0] sig = '0, last_a = '0;
  int           done_total = 0;

  always @(posedge clk) begin
    mdone_m <= 1'b0;
    if (rst) mont_op_valid <= 1'b0;
    if (mont_busy_m) begin
      if (mont_op_valid && !rst && (ifc.mont_a !== cap_a || ifc.mont_b !== cap_b))
        stab_errs <= stab_errs + 1;
      if (mont_cnt == 1) begin
        mdone_m       <= 1'b1;
        mres_m        <= mont_mul(cap_a, cap_b, cap_n);
        mont_busy_m   <= 1'b0;
        mont_op_valid <= 1'b0;
      end else begin
        mont_cnt <= mont_cnt - 1;
      end
    end
    if (ifc.mp_start) begin
      mont_pulses <= 0;
      sig         <= '0;
      eq_cnt      <= 0;
    end
    if (ifc.mont_start) begin
      if (mont_busy_m) mont_proto <= mont_proto + 1;
      cap_a         <= ifc.mont_a;
      cap_b         <= ifc.mont_b;
      cap_n         <= ifc.mont_n;
      mont_busy_m   <= 1'b1;
      mont_op_valid <= 1'b1;
      mont_cnt      <= int'($urandom_range(4, 2));
      mont_pulses   <= mont_pulses + 1;
      mont_total    <= mont_total + 1;
      sig           <= mix(sig, ifc.mont_a, ifc.mont_b);
      eq_cnt        <= eq_cnt + ((ifc.mont_a == ifc.mont_b) ? 1 : 0);
      last_a        <= ifc.mont_a;
    end
    if (ifc.done) done_total <= done_total + 1;
  end

  task automatic do_start(input logic [255:0] y, input logic [255:0] d, input logic [255:0] n,
                          input logic [255:0] expv);
    @(negedge clk);
    y_s = y; d_s = d; n_s = n;
    start_s = 1'b1;
    expq.push_back(expv);
    @(negedge clk);
    start_s = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (ifc.done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_mont(input bit want_sqr, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (ifc.mont_start && (!want_sqr || ifc.mont_a == ifc.mont_b)) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({ifc.result, ifc.done, ifc.busy, ifc.mp_start, ifc.mont_start} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got result=%0h done=%0b busy=%0b mp_start=%0b mont_start=%0b, want all 0",
               ifc.result, ifc.done, ifc.busy, ifc.mp_start, ifc.mont_start);
    end
    vectors++;
    if ({ifc.mont_a, ifc.mont_b, ifc.mont_n, ifc.mp_n, ifc.mp_a, ifc.mp_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_operands: got mont_a=%0h mont_b=%0h mont_n=%0h mp_n=%0h mp_a=%0h mp_b=%0h, want 0",
               ifc.mont_a, ifc.mont_b, ifc.mont_n, ifc.mp_n, ifc.mp_a, ifc.mp_b);
    end
    vectors++;
    if (ifc.mp_k !== 11'd256) begin
      miscompares++;
      $display("FAIL reset_mp_k: got %0d want 256", ifc.mp_k);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (ifc.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_busy: got %0b want 0", ifc.busy);
    end
  endtask

  task automatic test_basic();
    bit seen;
    logic [255:0] expv;
    do_start(256'd5, 256'd3, 256'd13, 256'd8);
    vectors++;
    if (ifc.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy_after_start: got %0b want 1", ifc.busy);
    end
    wait_done(seen);
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL basic_done_timeout: got no done want done");
    end
    expv = expq.pop_front();
    vectors++;
    if (ifc.result !== expv) begin
      miscompares++;
      $display("FAIL basic_result: got %0h want %0h", ifc.result, expv);
    end
    vectors++;
    if (ifc.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy_in_done: got %0b want 1", ifc.busy);
    end
    vectors++;
    if (mont_pulses !== PULSES_BASIC) begin
      miscompares++;
      $display("FAIL basic_mont_pulses: got %0d want %0d", mont_pulses, PULSES_BASIC);
    end
    vectors++;
    if (sig !== model_sig(256'd5, 256'd3, 256'd13)) begin
      miscompares++;
      $display("FAIL basic_operand_stream: got %0h want %0h", sig, model_sig(256'd5, 256'd3, 256'd13));
    end
    @(negedge clk);
    vectors++;
    if ({ifc.done, ifc.busy} !== 2'b00 || ifc.result !== expv) begin
      miscompares++;
      $display("FAIL basic_after_done: got done=%0b busy=%0b result=%0h want 0 0 %0h",
               ifc.done, ifc.busy, ifc.result, expv);
    end
  endtask

  task automatic test_zero_exp();
    bit seen;
    logic [255:0] expv;
    do_start(256'd7, 256'd0, 256'd11, 256'd1);
    wait_done(seen);
    expv = expq.pop_front();
    vectors++;
    if (!seen || ifc.result !== expv) begin
      miscompares++;
      $display("FAIL zero_exp_result: got seen=%0b result=%0h want 1 %0h", seen, ifc.result, expv);
    end
    vectors++;
    if (mont_pulses !== PULSES_ZERO) begin
      miscompares++;
      $display("FAIL zero_exp_pulses: got %0d want %0d", mont_pulses, PULSES_ZERO);
    end
  endtask

  task automatic test_top_bit();
    bit seen;
    logic [255:0] dv, nv, expv;
    dv = 256'd1 << 255;
    nv = (256'd1 << 255) - 256'd19;
    do_start(256'd2, dv, nv, ref_exp(256'd2, dv, nv));
    wait_done(seen);
    expv = expq.pop_front();
    vectors++;
    if (!seen || ifc.result !== expv) begin
      miscompares++;
      $display("FAIL top_bit_result: got seen=%0b result=%0h want 1 %0h", seen, ifc.result, expv);
    end
    vectors++;
    if (mont_pulses !== 256 || eq_cnt !== 255) begin
      miscompares++;
      $display("FAIL top_bit_ops: got pulses=%0d squarings=%0d want 256 255", mont_pulses, eq_cnt);
    end
    vectors++;
    if (last_a !== 256'd1) begin
      miscompares++;
      $display("FAIL top_bit_last_mul: got mont_a=%0h want 1", last_a);
    end
  endtask

  task automatic test_start_while_busy();
    bit seen;
    logic [255:0] expv;
    do_start(256'd5, 256'd3, 256'd13, 256'd8);
    wait_mont(1'b0, seen);
    y_s = 256'd9; d_s = 256'd7; n_s = 256'd11;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    vectors++;
    if (!seen || ifc.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_start_window: got seen=%0b busy=%0b want 1 1", seen, ifc.busy);
    end
    wait_done(seen);
    expv = expq.pop_front();
    vectors++;
    if (!seen || ifc.result !== expv) begin
      miscompares++;
      $display("FAIL busy_start_result: got seen=%0b result=%0h want 1 %0h", seen, ifc.result, expv);
    end
    vectors++;
    if (mont_pulses !== PULSES_BASIC || sig !== model_sig(256'd5, 256'd3, 256'd13)) begin
      miscompares++;
      $display("FAIL busy_start_stream: got pulses=%0d sig=%0h want %0d %0h",
               mont_pulses, sig, PULSES_BASIC, model_sig(256'd5, 256'd3, 256'd13));
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    int d0;
    logic [255:0] expv;
    do_start(256'd5, 256'd3, 256'd13, 256'd8);
    wait_mont(1'b1, seen);
    @(negedge clk);
    rst = 1'b1;
    d0 = done_total;
    @(negedge clk);
    vectors++;
    if (!seen || {ifc.mont_start, ifc.mp_start, ifc.busy, ifc.done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL abort_strobes: got seen=%0b mont_start=%0b mp_start=%0b busy=%0b done=%0b want 1 0 0 0 0",
               seen, ifc.mont_start, ifc.mp_start, ifc.busy, ifc.done);
    end
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    repeat (12) @(negedge clk);
    vectors++;
    if (done_total !== d0 || ifc.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: got dones=%0d busy=%0b want %0d 0", done_total, ifc.busy, d0);
    end
    do_start(256'd3, 256'd5, 256'd7, 256'd5);
    wait_done(seen);
    expv = expq.pop_front();
    vectors++;
    if (!seen || ifc.result !== expv) begin
      miscompares++;
      $display("FAIL abort_restart_result: got seen=%0b result=%0h want 1 %0h", seen, ifc.result, expv);
    end
    @(negedge clk);
    vectors++;
    if (done_total !== d0 + 1) begin
      miscompares++;
      $display("FAIL abort_done_count: got %0d want %0d", done_total, d0 + 1);
    end
  endtask

  task automatic test_spurious();
    bit seen;
    int mt0, mp0;
    logic [255:0] expv;
    @(negedge clk);
    mt0 = mont_total;
    mp0 = mp_total;
    mont_inj = 1'b1;
    mp_inj = 1'b1;
    @(negedge clk);
    mont_inj = 1'b0;
    mp_inj = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (ifc.busy !== 1'b0 || ifc.result !== 256'd5 || mont_total !== mt0 || mp_total !== mp0) begin
      miscompares++;
      $display("FAIL spurious_idle: got busy=%0b result=%0h mont=%0d mp=%0d want 0 5 %0d %0d",
               ifc.busy, ifc.result, mont_total, mp_total, mt0, mp0);
    end
    do_start(256'd5, 256'd3, 256'd13, 256'd8);
    wait_mont(1'b0, seen);
    mp_inj = 1'b1;
    @(negedge clk);
    mp_inj = 1'b0;
    wait_done(seen);
    expv = expq.pop_front();
    vectors++;
    if (!seen || ifc.result !== expv) begin
      miscompares++;
      $display("FAIL spurious_mulw_result: got seen=%0b result=%0h want 1 %0h", seen, ifc.result, expv);
    end
    vectors++;
    if (mont_pulses !== PULSES_BASIC || sig !== model_sig(256'd5, 256'd3, 256'd13)) begin
      miscompares++;
      $display("FAIL spurious_mulw_stream: got pulses=%0d sig=%0h want %0d %0h",
               mont_pulses, sig, PULSES_BASIC, model_sig(256'd5, 256'd3, 256'd13));
    end
  endtask

  task automatic test_protocol();
    vectors++;
    if (mont_proto !== 0 || mp_proto !== 0) begin
      miscompares++;
      $display("FAIL strobe_overlap: got mont=%0d mp=%0d want 0 0", mont_proto, mp_proto);
    end
    vectors++;
    if (stab_errs !== 0) begin
      miscompares++;
      $display("FAIL operand_stability: got %0d want 0", stab_errs);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_exp();
    test_top_bit();
    test_start_while_busy();
    test_reset_abort();
    test_spurious();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rsa_exp_sequencer.md
# rsa_exp_sequencer

Sequencer for the RSA 256-bit modular exponentiation path: computes y^d mod N by driving one ModuloProduct unit (R-domain precompute) and one shared Montgomery multiplier through their start/done handshakes. It sits between the wrapper that loads y, d and N and the two arithmetic units. It owns all loop control, bit scanning and operand routing. The arithmetic units hold no loop state.

## Interface
- `EXP_BITS`, default 256: exponent width and number of scanned bits.
- `clk` input 1: clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request pulse; samples `y`, `d`, `n`.
- `y`, `d`, `n` input 256 each: base, exponent, odd modulus.
- `result` output 256: y^d mod N; held until the next accepted `start`.
- `done` output 1: one-cycle pulse when `result` becomes valid.
- `busy` output 1: high from the cycle after an accepted `start` through the `done` cycle.
- `mp_start` output 1: one-cycle pulse to ModuloProduct.
- `mp_n`, `mp_a`, `mp_b` output 257 each: driven as {1'b0,n}, 1<<256, {1'b0,y}.
- `mp_k` output 11: constant 11'd256.
- `mp_done` input 1: ModuloProduct completion.
- `mp_result` input 257: ModuloProduct result; bits [255:0] used.
- `mont_start` output 1: one-cycle pulse to the Montgomery unit.
- `mont_a`, `mont_b`, `mont_n` output 256 each: Montgomery operands.
- `mont_done` input 1: Montgomery completion.
- `mont_result` input 256: Montgomery result.

## Operation
- Registers:
  - `y_r`, `d_r`, `n_r`: captured operands.
  - `t_r`: 256 bits, running power.
  - `m_r`: 256 bits, accumulator.
  - `i_r`: 9 bits, bit index.
- States: IDLE, PREP, PREP_W, MUL, MUL_W, SQR, SQR_W, DONE.
- IDLE:
  - `start` captures operands, clears `i_r`, sets `m_r`=1 and moves to PREP.
  - `start` in any other state is ignored.
- PREP: pulse `mp_start` and move to PREP_W.
- PREP_W: on `mp_done`, set `t_r`=`mp_result[255:0]` (y·2^256 mod N) and move to MUL.
- MUL:
  - If `d_r[i_r]`=1: drive `mont_a`=`m_r` and `mont_b`=`t_r`, pulse `mont_start`, move to MUL_W.
  - If `d_r[i_r]`=0: go straight to SQR with no pulse.
- MUL_W: on `mont_done`, set `m_r`=`mont_result` and move to SQR.
- SQR:
  - If `i_r`=EXP_BITS-1: go to DONE. The final squaring is never issued.
  - Otherwise: drive `mont_a`=`mont_b`=`t_r`, pulse `mont_start`, move to SQR_W.
- SQR_W: on `mont_done`, set `t_r`=`mont_result`, increment `i_r` and move to MUL.
- DONE: `result`←`m_r`, pulse `done`, return to IDLE.
- `mont_n`=`n_r` at all times. `mont_a` and `mont_b` are registered and stable from the `mont_start` cycle until the matching `mont_done`.
- `mp_done` outside PREP_W and `mont_done` outside MUL_W/SQR_W are ignored.
- No modulus range checks: even N or y≥N give undefined `result` but the sequence still terminates.

## Timing
- Reset values:
  - `result`=0, `done`=0, `busy`=0, `mp_start`=0, `mont_start`=0.
  - All operand outputs are 0; state is IDLE.
- Reset asserted mid-operation aborts immediately and deasserts both start strobes. Pending unit `done`s after reset are ignored.
- Every strobe is registered, exactly one cycle wide, and never reasserted before the matching `done`.
- A unit `done` is sampled no earlier than the cycle after its `start` pulse.
- `done` fires in the cycle after the last `mont_done`, or after the last skipped MUL when the final operation is a skip.
- Latency = 1 (accept) + (1 + L_mp) + Σ over issued Montgomery ops (1 + L_mont) + per-skip 1 + 1 (DONE).
- Issued Montgomery ops without early exit = popcount(d) + EXP_BITS − 1.

## Configuration
- `RSA_EARLY_EXIT_EN` defined:
  - In SQR, if `(d_r >> (i_r+1))`==0, go to DONE without squaring.
  - d=0 goes PREP_W→MUL→SQR→DONE with `result`=1.
- Undefined: always scan all EXP_BITS bits; results are identical, only latency differs.

## Test plan
- y=5, d=3, N=13, behavioral unit models → `result`=8.
  - Without the macro: 257 `mont_start` pulses.
  - With `RSA_EARLY_EXIT_EN`: 3 pulses.
- d=0, y=7, N=11 → `result`=1. Without the macro: 255 `mont_start` pulses (squarings only).
- d=2^255, y=2, N=2^255−19 → matches the reference model. Exactly 256 Montgomery ops, with MUL issued only at `i_r`=255.
- `start` pulsed while `busy` (in MUL_W) → ignored. `result` and `mont_start` sequence unchanged from the single-start run.
- `rst` asserted during SQR_W, then new `start` with y=3, d=5, N=7 → strobes low within reset, no `done` from the aborted run, `result`=5.
- Spurious `mont_done` in IDLE and `mp_done` in MUL_W → no state change, no register update.
